// File: rtl/fifo_rd_stream_if.sv
// Valid/ready stream carrying one word per handshake.
// The master drives valid/data and the slave drives ready.
interface fifo_rd_stream_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fifo_rd_stream.sv
// Read-side prefetch adapter: turns the FIFO's r_en / one-cycle-latency data /
// registered-empty interface into a valid/ready stream. A small circular buffer
// absorbs the read latency, so reads are issued from registered state only and
// never depend on the downstream ready.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 4,
  parameter int LVL_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  input  logic                  flush,
  fifo_rd_stream_if.master      m,
  output logic [LVL_W-1:0]      level
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int IDX_W = $clog2(BUF_DEPTH);
  localparam int SUM_W = CNT_W + 1;

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [IDX_W-1:0]      rd_idx;
  logic [IDX_W-1:0]      wr_idx;
  logic [CNT_W-1:0]      count;
  logic                  pending;
  logic                  room;
  logic                  capture;
  logic                  pop;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    if (idx == IDX_W'(BUF_DEPTH - 1)) begin
      return '0;
    end
    return idx + 1'b1;
  endfunction

  // An in-flight read already owns a slot, so it is counted when checking for room.
  assign room       = (SUM_W'(count) + SUM_W'(pending)) < SUM_W'(BUF_DEPTH);
  assign fifo_rd_en = !rst && !flush && !fifo_empty && room;
  assign capture    = pending && !flush;
  assign pop        = m.valid && m.ready;

  assign m.valid = (count != '0);
  assign m.data  = mem[rd_idx];
  assign level   = LVL_W'(count);

  // Buffer, indices, occupancy and in-flight tracking; flush drops in-flight data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_idx  <= '0;
      wr_idx  <= '0;
      count   <= '0;
      pending <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_idx  <= '0;
      wr_idx  <= '0;
      count   <= '0;
      pending <= 1'b0;
    end else begin
      pending <= fifo_rd_en;
      if (capture) begin
        mem[wr_idx] <= fifo_rdata;
        wr_idx      <= next_idx(wr_idx);
      end
      if (pop) begin
        rd_idx <= next_idx(rd_idx);
      end
      count <= count + CNT_W'(capture) - CNT_W'(pop);
    end
  end

`ifndef SYNTHESIS
  // Occupancy can never exceed the buffer size.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst) count <= CNT_W'(BUF_DEPTH));
  // A read is never issued against an empty FIFO.
  a_no_empty_read : assert property (@(posedge clk) fifo_rd_en |-> !fifo_empty);
`endif

endmodule
